// File: rtl/mips_ctrl_pkg.sv
// Shared pipeline-control constants: operand-mux select codes, hazard FSM state codes
// and the register-address width.
package mips_ctrl_pkg;

  localparam int NB_REG_ADDR = 5;

  localparam logic [1:0] FWD_SEL_RF    = 2'b00;
  localparam logic [1:0] FWD_SEL_EXMEM = 2'b01;
  localparam logic [1:0] FWD_SEL_MEMWB = 2'b10;

  localparam logic [1:0] ST_RUN      = 2'b00;
  localparam logic [1:0] ST_LU_STALL = 2'b01;
  localparam logic [1:0] ST_HOLD     = 2'b10;

endpackage

// File: rtl/fwd_sel_calc.sv
// Combinational forwarding priority for one ID source operand: EX beats MEM, r0 and
// bubbles never forward, and a load in EX is never forwarded from EX/MEM.
module fwd_sel_calc #(
  parameter int NB_REG_ADDR = mips_ctrl_pkg::NB_REG_ADDR,
  parameter int NB_SEL      = 2
) (
  input  logic [NB_REG_ADDR-1:0] src,
  input  logic                   id_valid,
  input  logic [NB_REG_ADDR-1:0] ex_rd,
  input  logic                   ex_regwrite,
  input  logic                   ex_memread,
  input  logic [NB_REG_ADDR-1:0] mem_rd,
  input  logic                   mem_regwrite,
  output logic [NB_SEL-1:0]      sel
);

  always_comb begin
    sel = mips_ctrl_pkg::FWD_SEL_RF;
    if (id_valid && (src != '0)) begin
      if (ex_regwrite && (ex_rd == src) && !ex_memread)
        sel = mips_ctrl_pkg::FWD_SEL_EXMEM;
      else if (mem_regwrite && (mem_rd == src))
        sel = mips_ctrl_pkg::FWD_SEL_MEMWB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select registers plus load-use / memory-wait stall FSM for the ID/EX boundary.
// Optional load-use stall cycle counter when FWD_HAZARD_STALL_CNT_EN is defined.
module fwd_hazard_ctrl #(
  parameter int NB_REG_ADDR = mips_ctrl_pkg::NB_REG_ADDR,
  parameter int NB_SEL      = 2
`ifdef FWD_HAZARD_STALL_CNT_EN
  ,
  parameter int NB_CNT      = 16
`endif
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NB_REG_ADDR-1:0] i_id_rs,
  input  logic [NB_REG_ADDR-1:0] i_id_rt,
  input  logic                   i_id_valid,
  input  logic [NB_REG_ADDR-1:0] i_ex_rd,
  input  logic                   i_ex_regwrite,
  input  logic                   i_ex_memread,
  input  logic [NB_REG_ADDR-1:0] i_mem_rd,
  input  logic                   i_mem_regwrite,
  input  logic                   i_mem_wait,
  output logic [NB_SEL-1:0]      o_fwd_a_sel,
  output logic [NB_SEL-1:0]      o_fwd_b_sel,
  output logic                   o_stall,
  output logic                   o_bubble,
  output logic                   o_hold_all
`ifdef FWD_HAZARD_STALL_CNT_EN
  ,
  output logic [NB_CNT-1:0]      o_lu_stall_cnt
`endif
);

  logic [1:0]        state, nxt_state;
  logic [NB_SEL-1:0] sel_a, sel_b, calc_a, calc_b, nxt_sel_a, nxt_sel_b;
  logic              load_use, stall, bubble, hold;

  fwd_sel_calc #(.NB_REG_ADDR(NB_REG_ADDR), .NB_SEL(NB_SEL)) u_calc_a (
    .src(i_id_rs), .id_valid(i_id_valid),
    .ex_rd(i_ex_rd), .ex_regwrite(i_ex_regwrite), .ex_memread(i_ex_memread),
    .mem_rd(i_mem_rd), .mem_regwrite(i_mem_regwrite), .sel(calc_a)
  );

  fwd_sel_calc #(.NB_REG_ADDR(NB_REG_ADDR), .NB_SEL(NB_SEL)) u_calc_b (
    .src(i_id_rt), .id_valid(i_id_valid),
    .ex_rd(i_ex_rd), .ex_regwrite(i_ex_regwrite), .ex_memread(i_ex_memread),
    .mem_rd(i_mem_rd), .mem_regwrite(i_mem_regwrite), .sel(calc_b)
  );

  assign load_use = i_id_valid && i_ex_memread && i_ex_regwrite && (i_ex_rd != '0) &&
                    ((i_ex_rd == i_id_rs) || (i_ex_rd == i_id_rt));

  // The cycle after a load-use stall the EX slot holds the bubble, so it is never re-stalled;
  // a HOLD cycle with the wait released behaves exactly like RUN.
  always_comb begin
    nxt_state = mips_ctrl_pkg::ST_RUN;
    nxt_sel_a = sel_a;
    nxt_sel_b = sel_b;
    stall     = 1'b0;
    bubble    = 1'b0;
    hold      = 1'b0;
    if (!i_rst) begin
      if (i_mem_wait) begin
        nxt_state = mips_ctrl_pkg::ST_HOLD;
        stall     = 1'b1;
        hold      = 1'b1;
      end else if (load_use && (state != mips_ctrl_pkg::ST_LU_STALL)) begin
        nxt_state = mips_ctrl_pkg::ST_LU_STALL;
        nxt_sel_a = mips_ctrl_pkg::FWD_SEL_RF;
        nxt_sel_b = mips_ctrl_pkg::FWD_SEL_RF;
        stall     = 1'b1;
        bubble    = 1'b1;
      end else begin
        nxt_sel_a = calc_a;
        nxt_sel_b = calc_b;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= mips_ctrl_pkg::ST_RUN;
      sel_a <= mips_ctrl_pkg::FWD_SEL_RF;
      sel_b <= mips_ctrl_pkg::FWD_SEL_RF;
    end else begin
      state <= nxt_state;
      sel_a <= nxt_sel_a;
      sel_b <= nxt_sel_b;
    end
  end

  assign o_fwd_a_sel = sel_a;
  assign o_fwd_b_sel = sel_b;
  assign o_stall     = stall;
  assign o_bubble    = bubble;
  assign o_hold_all  = hold;

`ifdef FWD_HAZARD_STALL_CNT_EN
  logic [NB_CNT-1:0] lu_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      lu_cnt <= '0;
    else if ((state == mips_ctrl_pkg::ST_LU_STALL) && (lu_cnt != '1))
      lu_cnt <= lu_cnt + 1'b1;
  end

  assign o_lu_stall_cnt = lu_cnt;
`endif

endmodule
